// File: rtl/bp_be_long_wb_sched_if.sv
// ---------------------------------------------------------------------------
// bp_be_long_wb_sched_if
//   Bundles every signal between the long-latency writeback scheduler and the
//   surrounding backend: dispatch issue and hazard check, the long pipe
//   result handshake, main-pipeline write occupancy and the register-file
//   write port. Clock and reset stay outside as plain ports.
//
//   slave  modport : the scheduler (inputs *_i, outputs *_o)
//   master modport : the environment driving the scheduler
// ---------------------------------------------------------------------------
interface bp_be_long_wb_sched_if #(
  parameter int data_width_p     = 65,
  parameter int reg_addr_width_p = 5
);
  // Control / dispatch
  logic                        flush_i;
  logic                        issue_v_i;
  logic [reg_addr_width_p-1:0] issue_rd_addr_i;
  logic                        issue_fp_i;
  logic                        ready_o;

  // Source-operand hazard check
  logic                        chk_rs1_v_i, chk_rs2_v_i, chk_rs3_v_i;
  logic [reg_addr_width_p-1:0] chk_rs1_i, chk_rs2_i, chk_rs3_i;
  logic                        chk_rs1_fp_i, chk_rs2_fp_i, chk_rs3_fp_i;
  logic                        hazard_o;

  // Long pipe result
  logic                        long_v_i;
  logic [data_width_p-1:0]     long_data_i;
  logic [4:0]                  long_fflags_i;
  logic                        long_yumi_o;

  // Main pipeline write-port occupancy and forced stall
  logic                        pipe_int_w_v_i;
  logic                        pipe_fp_w_v_i;
  logic                        stall_o;

  // Register-file write port
  logic                        int_w_v_o;
  logic                        fp_w_v_o;
  logic [reg_addr_width_p-1:0] w_addr_o;
  logic [data_width_p-1:0]     w_data_o;
  logic                        fflags_v_o;
  logic [4:0]                  w_fflags_o;

  modport slave (
    input  flush_i, issue_v_i, issue_rd_addr_i, issue_fp_i,
    input  chk_rs1_v_i, chk_rs2_v_i, chk_rs3_v_i,
    input  chk_rs1_i, chk_rs2_i, chk_rs3_i,
    input  chk_rs1_fp_i, chk_rs2_fp_i, chk_rs3_fp_i,
    input  long_v_i, long_data_i, long_fflags_i,
    input  pipe_int_w_v_i, pipe_fp_w_v_i,
    output ready_o, hazard_o, long_yumi_o, stall_o,
    output int_w_v_o, fp_w_v_o, w_addr_o, w_data_o, fflags_v_o, w_fflags_o
  );

  modport master (
    output flush_i, issue_v_i, issue_rd_addr_i, issue_fp_i,
    output chk_rs1_v_i, chk_rs2_v_i, chk_rs3_v_i,
    output chk_rs1_i, chk_rs2_i, chk_rs3_i,
    output chk_rs1_fp_i, chk_rs2_fp_i, chk_rs3_fp_i,
    output long_v_i, long_data_i, long_fflags_i,
    output pipe_int_w_v_i, pipe_fp_w_v_i,
    input  ready_o, hazard_o, long_yumi_o, stall_o,
    input  int_w_v_o, fp_w_v_o, w_addr_o, w_data_o, fflags_v_o, w_fflags_o
  );
endinterface

// File: rtl/bp_be_long_wb_sched.sv
// ---------------------------------------------------------------------------
// bp_be_long_wb_sched
//   Sequences the single outstanding long-latency op (int div/rem, FP
//   div/sqrt) against the main pipeline:
//     - tracks the pending destination and flags source hazards to dispatch
//     - holds the completed result and writes it into the int or FP file
//       whenever the main pipeline leaves that port free
//     - after starve_limit_p consecutive denials, spends one cycle in STALL
//       (stall_o=1) so the held result is written unconditionally
//
//   Ports:
//     clk_i     : clock
//     reset_n_i : asynchronous active-low reset
//     bus       : slave side of bp_be_long_wb_sched_if (dispatch, hazard
//                 check, long pipe handshake, pipe occupancy, write port)
// ---------------------------------------------------------------------------
module bp_be_long_wb_sched #(
  parameter int data_width_p     = 65,
  parameter int reg_addr_width_p = 5,
  parameter int starve_limit_p   = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bp_be_long_wb_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    HOLD  = 2'd2,
    STALL = 2'd3
  } state_e;

  localparam logic [3:0] STARVE_LIMIT = 4'(starve_limit_p);

  state_e                      r_state;
  logic [3:0]                  r_starve_cnt;
  logic                        r_stall;
  logic [reg_addr_width_p-1:0] r_rd_addr;
  logic                        r_rd_fp;
  logic [data_width_p-1:0]     r_data;
  logic [4:0]                  r_fflags;

  logic                        w_port_free;
  logic                        w_hold_go;
  logic                        w_stall_go;
  logic                        w_wr;
  logic                        w_int_w_v;
  logic                        w_fp_w_v;
  logic [3:0]                  w_starve_inc;
  logic                        w_hit1, w_hit2, w_hit3;
  logic                        w_rd_is_x0;

  // ------------------------------------------------------------------------
  // Write arbitration: the main pipeline owns the port it is using; the held
  // result only goes out when its target port is idle, or in STALL.
  // A flush cycle never writes.
  // ------------------------------------------------------------------------
  assign w_port_free = r_rd_fp ? ~bus.pipe_fp_w_v_i : ~bus.pipe_int_w_v_i;
  assign w_hold_go   = (r_state == HOLD)  & ~bus.flush_i & w_port_free;
  assign w_stall_go  = (r_state == STALL) & ~bus.flush_i;
  assign w_wr        = w_hold_go | w_stall_go;

  // x0 is hardwired zero: the op still retires, but nothing is written.
  assign w_rd_is_x0  = ~r_rd_fp & (r_rd_addr == '0);
  assign w_int_w_v   = w_wr & ~r_rd_fp & ~w_rd_is_x0;
  assign w_fp_w_v    = w_wr &  r_rd_fp;

  assign w_starve_inc = r_starve_cnt + 4'd1;

  // ------------------------------------------------------------------------
  // Hazard: any valid source naming the pending destination in the same
  // file. Integer x0 never hazards, FP f0 does.
  // ------------------------------------------------------------------------
  assign w_hit1 = bus.chk_rs1_v_i & (bus.chk_rs1_i == r_rd_addr) & (bus.chk_rs1_fp_i == r_rd_fp);
  assign w_hit2 = bus.chk_rs2_v_i & (bus.chk_rs2_i == r_rd_addr) & (bus.chk_rs2_fp_i == r_rd_fp);
  assign w_hit3 = bus.chk_rs3_v_i & (bus.chk_rs3_i == r_rd_addr) & (bus.chk_rs3_fp_i == r_rd_fp);

  assign bus.hazard_o    = (r_state != IDLE) & ~w_rd_is_x0 & (w_hit1 | w_hit2 | w_hit3);
  assign bus.ready_o     = (r_state == IDLE);
  // Results are always accepted; those outside BUSY or in a flush are dropped.
  assign bus.long_yumi_o = bus.long_v_i;
  assign bus.stall_o     = r_stall;

  assign bus.int_w_v_o   = w_int_w_v;
  assign bus.fp_w_v_o    = w_fp_w_v;
  assign bus.fflags_v_o  = w_fp_w_v;
  assign bus.w_fflags_o  = r_fflags;
  assign bus.w_addr_o    = (w_int_w_v | w_fp_w_v) ? r_rd_addr : '0;

  // Integer results carry only the low 64 bits; the recoding bit is zeroed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    bus.w_data_o = '0;
    if (w_fp_w_v)
      bus.w_data_o = r_data;
    else if (w_int_w_v)
      bus.w_data_o = {{(data_width_p-64){1'b0}}, r_data[63:0]};
  end

  // ------------------------------------------------------------------------
  // Control FSM and result hold register.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: the hold register is a single entry, not an array, so it is
      // reset with everything else; that keeps w_fflags_o at 0 out of reset.
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_fp      <= 1'b0;
      r_data       <= '0;
      r_fflags     <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      r_stall <= 1'b0;
      if (bus.flush_i) begin
        r_state      <= IDLE;
        r_starve_cnt <= '0;
        r_rd_addr    <= '0;
        r_rd_fp      <= 1'b0;
        r_data       <= '0;
        r_fflags     <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (bus.issue_v_i) begin
              r_rd_addr <= bus.issue_rd_addr_i;
              r_rd_fp   <= bus.issue_fp_i;
              r_state   <= BUSY;
            end
          end
          BUSY: begin
            if (bus.long_v_i) begin
              r_data   <= bus.long_data_i;
              r_fflags <= bus.long_fflags_i;
              r_state  <= HOLD;
            end
          end
          HOLD: begin
            if (w_hold_go) begin
              r_starve_cnt <= '0;
              r_state      <= IDLE;
            end else begin
              r_starve_cnt <= w_starve_inc;
              if (w_starve_inc == STARVE_LIMIT) begin
                r_state <= STALL;
                r_stall <= 1'b1;
              end
            end
          end
          STALL: begin
            r_starve_cnt <= '0;
            r_state      <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // ------------------------------------------------------------------------
  // Protocol checks on the environment.
  // ------------------------------------------------------------------------
  a_no_issue_when_busy : assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
      !(bus.issue_v_i && !bus.flush_i && r_state != IDLE));

  a_no_pipe_write_in_stall : assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
      !(r_state == STALL && !bus.flush_i && (bus.pipe_int_w_v_i || bus.pipe_fp_w_v_i)));

endmodule

// File: tb/tb_bp_be_long_wb_sched.sv
// ---------------------------------------------------------------------------
// tb_bp_be_long_wb_sched
//   Directed bench for bp_be_long_wb_sched (starve_limit_p = 4). Inputs are
//   changed 1 time unit after each rising edge, outputs are observed 1 unit
//   later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_bp_be_long_wb_sched;

  localparam int DW = 65;
  localparam int AW = 5;

  logic clk_i;
  logic reset_n_i;
  int   total;
  int   bad;

  bp_be_long_wb_sched_if #(.data_width_p(DW), .reg_addr_width_p(AW)) bus ();

  bp_be_long_wb_sched #(
    .data_width_p    (DW),
    .reg_addr_width_p(AW),
    .starve_limit_p  (4)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .bus      (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".int_w"}, 65'(bus.int_w_v_o), 65'd0);
    check({tag, ".fp_w"},  65'(bus.fp_w_v_o),  65'd0);
    check({tag, ".stall"}, 65'(bus.stall_o),   65'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n_i = 1'b0;
    bus.flush_i = 0; bus.issue_v_i = 0; bus.issue_rd_addr_i = '0; bus.issue_fp_i = 0;
    bus.chk_rs1_v_i = 0; bus.chk_rs2_v_i = 0; bus.chk_rs3_v_i = 0;
    bus.chk_rs1_i = '0; bus.chk_rs2_i = '0; bus.chk_rs3_i = '0;
    bus.chk_rs1_fp_i = 0; bus.chk_rs2_fp_i = 0; bus.chk_rs3_fp_i = 0;
    bus.long_v_i = 0; bus.long_data_i = '0; bus.long_fflags_i = '0;
    bus.pipe_int_w_v_i = 0; bus.pipe_fp_w_v_i = 0;

    // ---- Reset state ----
    #2;
    check("rst.ready",  65'(bus.ready_o),     65'd1);
    check("rst.hazard", 65'(bus.hazard_o),    65'd0);
    check("rst.yumi",   65'(bus.long_yumi_o), 65'd0);
    check("rst.waddr",  65'(bus.w_addr_o),    65'd0);
    check("rst.wdata",  bus.w_data_o,         65'd0);
    check("rst.fflags", 65'(bus.w_fflags_o),  65'd0);
    check_quiet("rst");
    #10 reset_n_i = 1'b1;

    // ---- Int op to x7, ports free ----
    tick();
    bus.issue_v_i = 1; bus.issue_rd_addr_i = 5'd7; bus.issue_fp_i = 0;
    settle();
    check("int.ready_pre", 65'(bus.ready_o), 65'd1);
    tick();                                   // now BUSY
    bus.issue_v_i = 0;
    bus.chk_rs1_v_i = 1; bus.chk_rs1_i = 5'd7; bus.chk_rs1_fp_i = 0;
    bus.long_v_i = 1; bus.long_data_i = 65'h2A; bus.long_fflags_i = 5'h00;
    settle();
    check("int.ready_busy", 65'(bus.ready_o),     65'd0);
    check("int.hazard_x7",  65'(bus.hazard_o),    65'd1);
    check("int.yumi",       65'(bus.long_yumi_o), 65'd1);
    check_quiet("int.busy");
    tick();                                   // HOLD, write goes out
    bus.long_v_i = 0; bus.chk_rs1_v_i = 0;
    settle();
    check("int.int_w", 65'(bus.int_w_v_o),  65'd1);
    check("int.fp_w",  65'(bus.fp_w_v_o),   65'd0);
    check("int.waddr", 65'(bus.w_addr_o),   65'd7);
    check("int.wdata", bus.w_data_o,        65'h2A);
    check("int.fv",    65'(bus.fflags_v_o), 65'd0);
    tick();
    settle();
    check("int.ready_post", 65'(bus.ready_o), 65'd1);
    check_quiet("int.post");

    // ---- FP op to f3, FP port starved -> forced stall ----
    bus.issue_v_i = 1; bus.issue_rd_addr_i = 5'd3; bus.issue_fp_i = 1;
    bus.pipe_fp_w_v_i = 1;
    tick();                                   // BUSY
    bus.issue_v_i = 0;
    bus.long_v_i = 1; bus.long_data_i = 65'h1_2345_6789_ABCD_EF01; bus.long_fflags_i = 5'h15;
    tick();                                   // HOLD, count 0
    bus.long_v_i = 0; bus.long_fflags_i = 5'h00;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("fp.deny%0d.fp_w", i),  65'(bus.fp_w_v_o), 65'd0);
      check($sformatf("fp.deny%0d.stall", i), 65'(bus.stall_o),  65'd0);
      tick();
    end
    // Pipeline reacts to stall_o by releasing its FP write.
    bus.pipe_fp_w_v_i = 0;
    settle();
    check("fp.stall",   65'(bus.stall_o),    65'd1);
    check("fp.fp_w",    65'(bus.fp_w_v_o),   65'd1);
    check("fp.int_w",   65'(bus.int_w_v_o),  65'd0);
    check("fp.waddr",   65'(bus.w_addr_o),   65'd3);
    check("fp.wdata",   bus.w_data_o,        65'h1_2345_6789_ABCD_EF01);
    check("fp.fv",      65'(bus.fflags_v_o), 65'd1);
    check("fp.fflags",  65'(bus.w_fflags_o), 65'h15);
    tick();
    settle();
    check("fp.ready_post", 65'(bus.ready_o), 65'd1);
    check_quiet("fp.post");

    // ---- FP op to f9 with only the int port busy: no stall ----
    bus.issue_v_i = 1; bus.issue_rd_addr_i = 5'd9; bus.issue_fp_i = 1;
    bus.pipe_int_w_v_i = 1;
    tick();
    bus.issue_v_i = 0;
    bus.long_v_i = 1; bus.long_data_i = 65'h1_0000_0000_0000_0003; bus.long_fflags_i = 5'h01;
    tick();                                   // HOLD
    bus.long_v_i = 0;
    settle();
    check("fpi.fp_w",   65'(bus.fp_w_v_o),   65'd1);
    check("fpi.stall",  65'(bus.stall_o),    65'd0);
    check("fpi.waddr",  65'(bus.w_addr_o),   65'd9);
    check("fpi.wdata",  bus.w_data_o,        65'h1_0000_0000_0000_0003);
    check("fpi.fflags", 65'(bus.w_fflags_o), 65'h01);
    tick();
    bus.pipe_int_w_v_i = 0;
    settle();
    check("fpi.ready_post", 65'(bus.ready_o), 65'd1);

    // ---- Hazards against pending int x5; int result truncated to 64 bits ----
    bus.issue_v_i = 1; bus.issue_rd_addr_i = 5'd5; bus.issue_fp_i = 0;
    tick();
    bus.issue_v_i = 0;
    bus.chk_rs2_v_i = 1; bus.chk_rs2_i = 5'd5; bus.chk_rs2_fp_i = 0;
    settle();
    check("hz.int_x5", 65'(bus.hazard_o), 65'd1);
    bus.chk_rs2_fp_i = 1;
    settle();
    check("hz.fp_f5", 65'(bus.hazard_o), 65'd0);
    bus.chk_rs2_fp_i = 0; bus.chk_rs2_v_i = 0;
    settle();
    check("hz.invalid", 65'(bus.hazard_o), 65'd0);
    bus.long_v_i = 1; bus.long_data_i = 65'h1_FFFF_0000_1234_5678;
    tick();
    bus.long_v_i = 0;
    settle();
    check("hz.int_w",  65'(bus.int_w_v_o), 65'd1);
    check("hz.wdata",  bus.w_data_o,       65'h0_FFFF_0000_1234_5678);
    tick();

    // ---- Pending FP f0 does hazard; then flushed ----
    bus.issue_v_i = 1; bus.issue_rd_addr_i = 5'd0; bus.issue_fp_i = 1;
    tick();
    bus.issue_v_i = 0;
    bus.chk_rs3_v_i = 1; bus.chk_rs3_i = 5'd0; bus.chk_rs3_fp_i = 1;
    settle();
    check("hz.fp_f0", 65'(bus.hazard_o), 65'd1);
    bus.chk_rs3_v_i = 0;
    bus.flush_i = 1;
    tick();
    bus.flush_i = 0;
    settle();
    check("hz.f0_flushed", 65'(bus.ready_o), 65'd1);

    // ---- Int op to x0: no hazard, no write, still retires ----
    bus.issue_v_i = 1; bus.issue_rd_addr_i = 5'd0; bus.issue_fp_i = 0;
    tick();
    bus.issue_v_i = 0;
    bus.chk_rs1_v_i = 1; bus.chk_rs1_i = 5'd0; bus.chk_rs1_fp_i = 0;
    settle();
    check("x0.hazard", 65'(bus.hazard_o), 65'd0);
    check("x0.ready",  65'(bus.ready_o),  65'd0);
    bus.chk_rs1_v_i = 0;
    bus.long_v_i = 1; bus.long_data_i = 65'h55;
    tick();
    bus.long_v_i = 0;
    settle();
    check("x0.int_w", 65'(bus.int_w_v_o), 65'd0);
    check("x0.waddr", 65'(bus.w_addr_o),  65'd0);
    check("x0.wdata", bus.w_data_o,       65'd0);
    tick();
    settle();
    check("x0.ready_post", 65'(bus.ready_o), 65'd1);

    // ---- Flush in BUSY, late result discarded ----
    bus.issue_v_i = 1; bus.issue_rd_addr_i = 5'd4; bus.issue_fp_i = 0;
    tick();
    bus.issue_v_i = 0;
    bus.flush_i = 1;
    tick();
    bus.flush_i = 0;
    bus.long_v_i = 1; bus.long_data_i = 65'h99;
    settle();
    check("flb.yumi",  65'(bus.long_yumi_o), 65'd1);
    check("flb.ready", 65'(bus.ready_o),     65'd1);
    tick();
    bus.long_v_i = 0;
    settle();
    check("flb.ready_post", 65'(bus.ready_o), 65'd1);
    check_quiet("flb.post");

    // ---- Flush in HOLD with port free: no write ----
    bus.issue_v_i = 1; bus.issue_rd_addr_i = 5'd6; bus.issue_fp_i = 0;
    tick();
    bus.issue_v_i = 0;
    bus.long_v_i = 1; bus.long_data_i = 65'h77;
    tick();                                   // HOLD
    bus.long_v_i = 0;
    bus.flush_i = 1;
    settle();
    check("flh.int_w", 65'(bus.int_w_v_o), 65'd0);
    check("flh.wdata", bus.w_data_o,       65'd0);
    tick();
    bus.flush_i = 0;
    settle();
    check("flh.ready", 65'(bus.ready_o), 65'd1);
    check_quiet("flh.post");

    // ---- Flush and issue together: issue dropped ----
    bus.issue_v_i = 1; bus.issue_rd_addr_i = 5'd2; bus.issue_fp_i = 0;
    bus.flush_i = 1;
    tick();
    bus.issue_v_i = 0; bus.flush_i = 0;
    settle();
    check("fli.ready", 65'(bus.ready_o), 65'd1);

    // ---- Async reset mid-HOLD ----
    bus.issue_v_i = 1; bus.issue_rd_addr_i = 5'd8; bus.issue_fp_i = 0;
    tick();
    bus.issue_v_i = 0;
    bus.long_v_i = 1; bus.long_data_i = 65'h1234;
    tick();                                   // HOLD, write visible
    bus.long_v_i = 0;
    settle();
    check("rsth.int_w_before", 65'(bus.int_w_v_o), 65'd1);
    reset_n_i = 1'b0;                         // between edges
    settle();
    check("rsth.ready", 65'(bus.ready_o),  65'd1);
    check("rsth.waddr", 65'(bus.w_addr_o), 65'd0);
    check("rsth.wdata", bus.w_data_o,      65'd0);
    check_quiet("rsth.in_reset");
    #2 reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      check($sformatf("rsth.after%0d.int_w", i), 65'(bus.int_w_v_o), 65'd0);
      check($sformatf("rsth.after%0d.ready", i), 65'(bus.ready_o),   65'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
